// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: start/ack handshake, pause/abort
// controls and the registered count/status outputs.
interface down_counter_timer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] v;
  logic             pause;
  logic             abort;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output start, v, pause, abort, ack,
    input  count, busy, done, tc
  );

  modport slave (
    input  start, v, pause, abort, ack,
    output count, busy, done, tc
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable one-shot down-counter with start/ack handshake, pause and abort.
// Define COUNTER_RELOAD_EN for periodic mode (reload on zero, never DONE).
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             load;

`ifdef COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // A load happens from IDLE on start, or from DONE when ack and start coincide.
  assign load = bus.start && ((state_q == IDLE) || (state_q == DONE && bus.ack));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef COUNTER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      count_d = bus.v;
`ifdef COUNTER_RELOAD_EN
      reload_d = bus.v;
`endif
      if (bus.v == '0) begin
        state_d = DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (!bus.pause) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
`ifdef COUNTER_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          count_d = '0;
          if (bus.ack) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

`ifdef COUNTER_RELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) reload_q <= '0;
    else     reload_q <= reload_d;
  end
`endif

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: reset, countdown, pause, zero load,
// back-to-back restart, abort/reset mid-run, max preload, and periodic mode.
module tb_down_counter_timer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic b, input logic d, input logic t);
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
    chk({tag, ".tc"},    32'(bus.tc),    32'(t));
  endtask

  initial begin
    // reset with random inputs applied
    rst       = 1'b1;
    bus.start = 1'($urandom);
    bus.v     = WIDTH'($urandom);
    bus.pause = 1'($urandom);
    bus.abort = 1'($urandom);
    bus.ack   = 1'($urandom);
    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    bus.start = 0; bus.v = 0; bus.pause = 0; bus.abort = 0; bus.ack = 0;
    step();
    chk_all("idle_hold", 0, 0, 0, 0);

    // v=5 countdown
    bus.start = 1; bus.v = 5;
    step();
    bus.start = 0; bus.v = 0;
    chk_all("run5_load", 5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk_all("run5_dec", i, 1, 0, 0);
    end
    step();
    chk_all("run5_zero", 0, 0, 1, 1);
    step();
    chk_all("run5_done_hold", 0, 0, 1, 0);
    step();
    chk_all("run5_done_hold2", 0, 0, 1, 0);
    bus.ack = 1;
    step();
    bus.ack = 0;
    chk_all("run5_ack", 0, 0, 0, 0);

    // v=6 with 3-cycle pause at count 4; start during RUN ignored
    bus.start = 1; bus.v = 6;
    step();
    bus.v = 99;
    chk_all("pause_load", 6, 1, 0, 0);
    step();
    chk_all("pause_dec5", 5, 1, 0, 0);
    step();
    bus.start = 0;
    chk_all("pause_dec4", 4, 1, 0, 0);
    bus.pause = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("pause_hold", 4, 1, 0, 0);
    end
    bus.pause = 0;
    for (int i = 3; i >= 1; i--) begin
      step();
      chk_all("pause_dec", i, 1, 0, 0);
    end
    step();
    chk_all("pause_zero", 0, 0, 1, 1);
    bus.ack = 1;
    step();
    bus.ack = 0;
    chk_all("pause_ack", 0, 0, 0, 0);

    // pause at count==1 holds there
    bus.start = 1; bus.v = 1;
    step();
    bus.start = 0;
    chk_all("p1_load", 1, 1, 0, 0);
    bus.pause = 1;
    step();
    chk_all("p1_hold", 1, 1, 0, 0);
    bus.pause = 0;
    step();
    chk_all("p1_zero", 0, 0, 1, 1);
    bus.ack = 1;
    step();
    bus.ack = 0;

    // v=0 load goes straight to DONE
    bus.start = 1; bus.v = 0;
    step();
    bus.start = 0;
    chk_all("zero_load", 0, 0, 1, 1);
    step();
    chk_all("zero_hold", 0, 0, 1, 0);

    // back-to-back: ack+start in DONE
    bus.ack = 1; bus.start = 1; bus.v = 3;
    step();
    bus.ack = 0; bus.start = 0; bus.v = 0;
    chk_all("b2b_load", 3, 1, 0, 0);
    step();
    chk_all("b2b_dec2", 2, 1, 0, 0);
    step();
    chk_all("b2b_dec1", 1, 1, 0, 0);
    step();
    chk_all("b2b_zero", 0, 0, 1, 1);
    // start without ack ignored in DONE
    bus.start = 1; bus.v = 9;
    step();
    chk_all("done_start_noack", 0, 0, 1, 0);
    bus.start = 0; bus.ack = 1;
    step();
    bus.ack = 0;
    chk_all("done_ack_idle", 0, 0, 0, 0);

    // abort at count 7
    bus.start = 1; bus.v = 10;
    step();
    bus.start = 0;
    chk_all("abort_load", 10, 1, 0, 0);
    step(); step(); step();
    chk_all("abort_pre", 7, 1, 0, 0);
    bus.abort = 1;
    step();
    bus.abort = 0;
    chk_all("abort_idle", 0, 0, 0, 0);
    step();
    chk_all("abort_stay", 0, 0, 0, 0);

    // abort beats start
    bus.start = 1; bus.v = 5; bus.abort = 1;
    step();
    bus.start = 0; bus.abort = 0;
    chk_all("abort_vs_start", 0, 0, 0, 0);

    // reset at count 4 in a second run
    bus.start = 1; bus.v = 10;
    step();
    bus.start = 0;
    for (int i = 0; i < 6; i++) step();
    chk_all("rst_pre", 4, 1, 0, 0);
    rst = 1;
    step();
    rst = 0;
    chk_all("rst_mid", 0, 0, 0, 0);

    // maximum preload
    bus.start = 1; bus.v = 8'hFF;
    step();
    bus.start = 0;
    chk_all("max_load", 255, 1, 0, 0);
    step();
    chk_all("max_dec", 254, 1, 0, 0);
    bus.abort = 1;
    step();
    bus.abort = 0;
    chk_all("max_abort", 0, 0, 0, 0);

`ifdef COUNTER_RELOAD_EN
    // periodic mode: 4,3,2,1,4,... with tc on each reload
    bus.start = 1; bus.v = 4;
    step();
    bus.start = 0;
    chk_all("rl_load", 4, 1, 0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 3; i >= 1; i--) begin
        step();
        chk_all("rl_dec", i, 1, 0, 0);
      end
      step();
      chk_all("rl_reload", 4, 1, 0, 1);
    end
    bus.abort = 1;
    step();
    bus.abort = 0;
    chk_all("rl_abort", 0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
